// File: rtl/axi_4_lite_master_if.sv
// Signal bundle between the AXI4-Lite master, its local command/response user and the AXI4-Lite slave.
// The master modport is the initiator's view; the slave modport is the view of everything around it.
interface axi_4_lite_master_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    CMD_VALID;
  logic                    CMD_READY;
  logic                    CMD_WRITE;
  logic [ADDRESS-1:0]      CMD_ADDR;
  logic [DATA_WIDTH-1:0]   CMD_WDATA;
  logic [DATA_WIDTH/8-1:0] CMD_WSTRB;
  logic                    RSP_VALID;
  logic                    RSP_READY;
  logic                    RSP_WRITE;
  logic [DATA_WIDTH-1:0]   RSP_RDATA;
  logic [1:0]              RSP_RESP;
  logic [ADDRESS-1:0]      M_AWADDR;
  logic                    M_AWVALID;
  logic                    M_AWREADY;
  logic [DATA_WIDTH-1:0]   M_WDATA;
  logic [DATA_WIDTH/8-1:0] M_WSTRB;
  logic                    M_WVALID;
  logic                    M_WREADY;
  logic                    M_BREADY;
  logic [1:0]              M_BRESP;
  logic                    M_BVALID;
  logic [ADDRESS-1:0]      M_ARADDR;
  logic                    M_ARVALID;
  logic                    M_ARREADY;
  logic                    M_RREADY;
  logic [DATA_WIDTH-1:0]   M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RVALID;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
    output CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
    output M_ARADDR, M_ARVALID, M_RREADY,
    input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
    input  CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
    input  M_ARADDR, M_ARVALID, M_RREADY,
    output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );
endinterface

// File: rtl/axi_4_lite_master.sv
// AXI4-Lite initiator: turns one local command at a time into a single-beat write or read
// and returns the slave's response, unmodified, on the local response port.
module axi_4_lite_master #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                 CLK,
  input logic                 RESET,
  axi_4_lite_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RSP} state_t;

  state_t                  r_state;
  logic [ADDRESS-1:0]      r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_bready;
  logic [ADDRESS-1:0]      r_araddr;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_rsp_valid;
  logic                    r_rsp_write;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;

  logic w_cmd_ready;
  logic w_cmd_fire;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_ok;
  logic w_w_ok;

  assign w_cmd_ready = (r_state == IDLE) && !RESET;
  assign w_cmd_fire  = bus.CMD_VALID && w_cmd_ready;
  assign w_aw_hs     = r_awvalid && bus.M_AWREADY;
  assign w_w_hs      = r_wvalid && bus.M_WREADY;
  // A flag and a same-cycle handshake count equally, so simultaneous AW/W completes at once.
  assign w_aw_ok     = r_aw_done || w_aw_hs;
  assign w_w_ok      = r_w_done || w_w_hs;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_rsp_write <= bus.CMD_WRITE;
            if (bus.CMD_WRITE) begin
              r_awaddr  <= bus.CMD_ADDR;
              r_wdata   <= bus.CMD_WDATA;
              r_wstrb   <= bus.CMD_WSTRB;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= WRITE;
            end else begin
              r_araddr  <= bus.CMD_ADDR;
              r_arvalid <= 1'b1;
              r_state   <= READ;
            end
          end
        end
        WRITE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= WRESP;
          end
        end
        WRESP: begin
          if (bus.M_BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= bus.M_BRESP;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        READ: begin
          if (bus.M_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (bus.M_RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= bus.M_RDATA;
            r_rsp_resp  <= bus.M_RRESP;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end
        RSP: begin
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.CMD_READY = w_cmd_ready;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_WRITE = r_rsp_write;
  assign bus.RSP_RDATA = r_rsp_rdata;
  assign bus.RSP_RESP  = r_rsp_resp;
  assign bus.M_AWADDR  = r_awaddr;
  assign bus.M_AWVALID = r_awvalid;
  assign bus.M_WDATA   = r_wdata;
  assign bus.M_WSTRB   = r_wstrb;
  assign bus.M_WVALID  = r_wvalid;
  assign bus.M_BREADY  = r_bready;
  assign bus.M_ARADDR  = r_araddr;
  assign bus.M_ARVALID = r_arvalid;
  assign bus.M_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_4_lite_master.sv
// Bench for axi_4_lite_master: a small register-file slave with programmable ready/response
// behaviour, a table of single commands, and hand-written multi-cycle sequences.
module tb_axi_4_lite_master;

  logic CLK;
  logic RESET;

  axi_4_lite_master_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

  axi_4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Slave model configuration
  int         aw_delay = 0;
  int         w_delay  = 0;
  int         r_delay  = 0;
  logic [1:0] bresp_cfg = 2'b00;
  bit         mem_clear_en = 1'b1;

  logic [31:0] mem [0:63];
  int          s_aw_cnt, s_w_cnt, s_r_left;
  logic        s_got_aw, s_got_w, s_bvalid, s_rvalid, s_r_pend;
  logic [31:0] s_aw_addr, s_wdata, s_rdata, s_r_addr, s_last_awaddr;
  logic [3:0]  s_wstrb, s_last_wstrb;
  logic [1:0]  s_bresp;
  logic        s_aw_hs, s_w_hs;
  logic [31:0] s_eff_addr, s_eff_data;
  logic [3:0]  s_eff_strb;

  assign bus.M_AWREADY = bus.M_AWVALID && (s_aw_cnt >= aw_delay);
  assign bus.M_WREADY  = bus.M_WVALID && (s_w_cnt >= w_delay);
  assign bus.M_ARREADY = bus.M_ARVALID;
  assign bus.M_BVALID  = s_bvalid;
  assign bus.M_BRESP   = s_bresp;
  assign bus.M_RVALID  = s_rvalid;
  assign bus.M_RDATA   = s_rdata;
  assign bus.M_RRESP   = 2'b00;
  assign s_aw_hs    = bus.M_AWVALID && bus.M_AWREADY;
  assign s_w_hs     = bus.M_WVALID && bus.M_WREADY;
  assign s_eff_addr = s_got_aw ? s_aw_addr : bus.M_AWADDR;
  assign s_eff_data = s_got_w ? s_wdata : bus.M_WDATA;
  assign s_eff_strb = s_got_w ? s_wstrb : bus.M_WSTRB;

  always @(posedge CLK) begin
    if (RESET) begin
      s_aw_cnt <= 0;
      s_w_cnt  <= 0;
      s_got_aw <= 1'b0;
      s_got_w  <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_r_pend <= 1'b0;
      if (mem_clear_en) for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      s_aw_cnt <= (bus.M_AWVALID && !bus.M_AWREADY) ? s_aw_cnt + 1 : 0;
      s_w_cnt  <= (bus.M_WVALID && !bus.M_WREADY) ? s_w_cnt + 1 : 0;
      if (s_aw_hs) begin
        s_got_aw      <= 1'b1;
        s_aw_addr     <= bus.M_AWADDR;
        s_last_awaddr <= bus.M_AWADDR;
      end
      if (s_w_hs) begin
        s_got_w      <= 1'b1;
        s_wdata      <= bus.M_WDATA;
        s_wstrb      <= bus.M_WSTRB;
        s_last_wstrb <= bus.M_WSTRB;
      end
      if (s_bvalid && bus.M_BREADY) s_bvalid <= 1'b0;
      if ((s_got_aw || s_aw_hs) && (s_got_w || s_w_hs) && !s_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (s_eff_strb[b]) mem[s_eff_addr[7:2]][8*b +: 8] <= s_eff_data[8*b +: 8];
        s_bvalid <= 1'b1;
        s_bresp  <= bresp_cfg;
        s_got_aw <= 1'b0;
        s_got_w  <= 1'b0;
      end
      if (s_rvalid && bus.M_RREADY) s_rvalid <= 1'b0;
      if (bus.M_ARVALID && bus.M_ARREADY) begin
        if (r_delay == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= mem[bus.M_ARADDR[7:2]];
        end else begin
          s_r_pend <= 1'b1;
          s_r_left <= r_delay - 1;
          s_r_addr <= bus.M_ARADDR;
        end
      end else if (s_r_pend) begin
        if (s_r_left == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= mem[s_r_addr[7:2]];
          s_r_pend <= 1'b0;
        end else begin
          s_r_left <= s_r_left - 1;
        end
      end
    end
  end

  int bready_cyc = 0;
  always @(negedge CLK) bready_cyc <= bready_cyc + (bus.M_BREADY ? 1 : 0);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Offers a command from a negedge; returns at the negedge of the cycle after acceptance.
  task automatic accept(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    bit ok;
    ok = 1'b0;
    bus.CMD_WRITE = w;
    bus.CMD_ADDR  = a;
    bus.CMD_WDATA = d;
    bus.CMD_WSTRB = s;
    bus.CMD_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.CMD_READY) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    if (!ok) timeout("cmd_accept");
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output logic rw);
    bit ok;
    ok = 1'b0;
    rd = '0;
    rs = '0;
    rw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.RSP_VALID) begin
        ok = 1'b1;
        rd = bus.RSP_RDATA;
        rs = bus.RSP_RESP;
        rw = bus.RSP_WRITE;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    if (!ok) timeout("rsp_wait");
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] rd;
  logic [1:0]  rs;
  logic        rw;
  int          b0, cnt, k, cyc;
  int          acc_cyc [4];
  logic [31:0] bb_addr [4];
  logic [31:0] bb_data [4];

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'b1111, 32'h0, 2'b00};
    tbl[1] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h1234_5678, 2'b00};
    tbl[2] = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'b1010, 32'h0, 2'b00};
    tbl[3] = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'hAA00_CC00, 2'b00};
    tbl[4] = '{1'b1, 32'h0000_1003, 32'hFFFF_FFFF, 4'b0000, 32'h0, 2'b00};
    tbl[5] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h1234_5678, 2'b00};
    bb_addr = '{32'h8, 32'hC, 32'h10, 32'h14};
    bb_data = '{32'hDEADBEEF, 32'hCAFEBABE, 32'hFEEDFACE, 32'hBABEC0DE};

    RESET         = 1'b1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = '0;
    bus.CMD_WDATA = '0;
    bus.CMD_WSTRB = '0;
    bus.RSP_READY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_cmd_ready", 32'(bus.CMD_READY), 32'h0);
    chk("rst_valids", 32'({bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID, bus.RSP_VALID}), 32'h0);
    chk("rst_readys", 32'({bus.M_BREADY, bus.M_RREADY}), 32'h0);
    chk("rst_awaddr", bus.M_AWADDR, 32'h0);
    chk("rst_rsp", 32'({bus.RSP_WRITE, bus.RSP_RESP}) | bus.RSP_RDATA, 32'h0);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
      wait_rsp(rd, rs, rw);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_resp", i), 32'(rs), 32'(tbl[i].exp_resp));
      chk($sformatf("vec%0d_write", i), 32'(rw), 32'(tbl[i].w));
      if (tbl[i].w) begin
        chk($sformatf("vec%0d_awaddr", i), s_last_awaddr, tbl[i].addr);
        chk($sformatf("vec%0d_wstrb", i), 32'(s_last_wstrb), 32'(tbl[i].strb));
      end
    end

    // Zero-wait latency: accept in cycle 0, VALIDs cycle 1, BVALID cycle 2, RSP_VALID cycle 3
    accept(1'b1, 32'h30, 32'h55AA_55AA, 4'hF);
    chk("lat_c1_valids", 32'({bus.M_AWVALID, bus.M_WVALID, bus.CMD_READY}), 32'b110);
    @(negedge CLK);
    chk("lat_c2_b", 32'({bus.M_BVALID, bus.M_BREADY, bus.M_AWVALID, bus.M_WVALID}), 32'b1100);
    @(negedge CLK);
    chk("lat_c3_rsp", 32'({bus.RSP_VALID, bus.RSP_WRITE, bus.RSP_RESP}), 32'b1100);
    @(negedge CLK);
    chk("lat_c4_idle", 32'({bus.RSP_VALID, bus.CMD_READY}), 32'b01);

    // AWREADY three cycles ahead of WREADY, then the reverse
    aw_delay = 0; w_delay = 3;
    b0 = bready_cyc;
    accept(1'b1, 32'h20, 32'h0102_0304, 4'hF);
    @(negedge CLK);
    chk("aw_first_c2", 32'({bus.M_AWVALID, bus.M_WVALID}), 32'b01);
    wait_rsp(rd, rs, rw);
    chk("aw_first_resp", 32'(rs), 32'h0);
    chk("aw_first_bready", 32'(bready_cyc - b0), 32'd1);
    aw_delay = 3; w_delay = 0;
    b0 = bready_cyc;
    accept(1'b1, 32'h24, 32'h0506_0708, 4'hF);
    @(negedge CLK);
    chk("w_first_c2", 32'({bus.M_AWVALID, bus.M_WVALID}), 32'b10);
    wait_rsp(rd, rs, rw);
    chk("w_first_resp", 32'(rs), 32'h0);
    chk("w_first_bready", 32'(bready_cyc - b0), 32'd1);
    aw_delay = 0; w_delay = 0;
    accept(1'b0, 32'h20, 32'h0, 4'h0);
    wait_rsp(rd, rs, rw);
    chk("aw_first_rd", rd, 32'h0102_0304);
    accept(1'b0, 32'h24, 32'h0, 4'h0);
    wait_rsp(rd, rs, rw);
    chk("w_first_rd", rd, 32'h0506_0708);

    // Back-to-back writes with CMD_VALID held high
    k = 0; cyc = 0;
    bus.CMD_WRITE = 1'b1;
    bus.CMD_WSTRB = 4'hF;
    bus.CMD_ADDR  = bb_addr[0];
    bus.CMD_WDATA = bb_data[0];
    bus.CMD_VALID = 1'b1;
    while (k < 4 && cyc < 200) begin
      if (bus.CMD_READY) begin
        acc_cyc[k] = cyc;
        k++;
      end
      @(negedge CLK);
      cyc++;
      if (k < 4) begin
        bus.CMD_ADDR  = bb_addr[k];
        bus.CMD_WDATA = bb_data[k];
      end else begin
        bus.CMD_VALID = 1'b0;
      end
    end
    bus.CMD_VALID = 1'b0;
    chk("bb_accepts", 32'(k), 32'd4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("bb_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
    cnt = 0;
    while (!bus.CMD_READY && cnt < 100) begin
      @(negedge CLK);
      cnt++;
    end
    if (cnt >= 100) timeout("bb_drain");
    for (int i = 0; i < 4; i++) begin
      accept(1'b0, bb_addr[i], 32'h0, 4'h0);
      wait_rsp(rd, rs, rw);
      chk($sformatf("bb_rd%0d", i), rd, bb_data[i]);
    end

    // SLVERR with the response held off for five cycles
    bresp_cfg = 2'b10;
    bus.RSP_READY = 1'b0;
    accept(1'b1, 32'h1030, 32'h0BAD_F00D, 4'hF);
    cnt = 0;
    while (!bus.RSP_VALID && cnt < 100) begin
      @(negedge CLK);
      cnt++;
    end
    if (cnt >= 100) timeout("slverr_rsp");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), 32'({bus.RSP_VALID, bus.RSP_WRITE, bus.RSP_RESP}) | bus.RSP_RDATA,
          32'b1110);
      @(negedge CLK);
    end
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    chk("hold_release", 32'({bus.RSP_VALID, bus.CMD_READY}), 32'b01);
    bresp_cfg = 2'b00;

    // Reset while waiting in RDATA
    mem_clear_en = 1'b0;
    r_delay = 20;
    accept(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge CLK);
    chk("rdata_rready", 32'(bus.M_RREADY), 32'h1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_outs", 32'({bus.M_RREADY, bus.RSP_VALID, bus.M_ARVALID, bus.CMD_READY}), 32'h0);
    RESET = 1'b0;
    r_delay = 0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.RSP_VALID) cnt++;
      @(negedge CLK);
    end
    chk("midrst_no_rsp", 32'(cnt), 32'd0);
    accept(1'b0, 32'h0, 32'h0, 4'h0);
    wait_rsp(rd, rs, rw);
    chk("post_rst_rd", rd, 32'h1234_5678);
    chk("post_rst_meta", 32'({rw, rs}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
